// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the cache-side AXI read path.
// Used by axi_rd_arbiter and axi_rd_grant.
package axi_rd_arbiter_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Grant select encoding: 0 = instruction side, 1 = data side
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Read request as issued by either cache
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
    } cache_rd_req_t;

    // Cache miss source
    typedef enum logic {
        SRC_ICACHE = 1'b0,
        SRC_DCACHE = 1'b1
    } cache_src_t;

endpackage

// File: rtl/axi_rd_grant.sv
// Combinational grant select between the two cache read requesters.
// On a tie the side that was not granted last wins (last_gnt).
module axi_rd_grant
    import axi_rd_arbiter_pkg::*;
(
    input  logic i_valid,
    input  logic d_valid,
    input  logic last_gnt,
    output logic gnt_d
);

    // Lone requester wins; a tie goes to the side opposite last_gnt
    always_comb begin
        gnt_d = GNT_I;
        if (d_valid && !i_valid) begin
            gnt_d = GNT_D;
        end else if (d_valid && i_valid) begin
            gnt_d = (last_gnt == GNT_I) ? GNT_D : GNT_I;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter, one outstanding read at a time.
// Optional macro AXI_ARB_ROUND_ROBIN_EN: round-robin tie-break.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter logic [3:0] ICACHE_ID = 4'd0,
    parameter logic [3:0] DCACHE_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    // instruction-side request
    input  logic        i_i_req_valid,
    output logic        o_i_req_ready,
    input  logic [31:0] i_i_req_addr,
    input  logic [3:0]  i_i_req_len,
    input  logic [2:0]  i_i_req_size,
    // data-side request
    input  logic        i_d_req_valid,
    output logic        o_d_req_ready,
    input  logic [31:0] i_d_req_addr,
    input  logic [3:0]  i_d_req_len,
    input  logic [2:0]  i_d_req_size,
    // return path
    output logic        o_i_rvalid,
    output logic        o_d_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_rlast,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // status
    output logic        o_err,
    output logic        o_busy
);

    arb_state_t    state_q, state_d;
    cache_rd_req_t req_q, req_d;
    logic [3:0]    arid_q, arid_d;
    logic          own_d_q, own_d_d;
    logic [3:0]    beat_q, beat_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          gnt_d;
    logic          last_gnt;
    logic          gnt_any;
    logic          in_idle;
    cache_rd_req_t i_req, d_req;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // Side that wins the next tie; starts on the data side
    logic rr_ptr_q, rr_ptr_d;
    assign last_gnt = ~rr_ptr_q;
`else
    assign last_gnt = GNT_I;
`endif

    assign i_req   = '{addr: i_i_req_addr,
                       len:  i_i_req_len,
                       size: i_i_req_size};
    assign d_req   = '{addr: i_d_req_addr,
                       len:  i_d_req_len,
                       size: i_d_req_size};

    assign in_idle = (state_q == IDLE);
    assign gnt_any = in_idle && (i_i_req_valid || i_d_req_valid);

    axi_rd_grant u_grant (
        .i_valid  (i_i_req_valid),
        .d_valid  (i_d_req_valid),
        .last_gnt (last_gnt),
        .gnt_d    (gnt_d)
    );

    // Grant pulse is same-cycle; reset gating keeps it low in reset
    assign o_i_req_ready = aresetn && gnt_any && (gnt_d == GNT_I);
    assign o_d_req_ready = aresetn && gnt_any && (gnt_d == GNT_D);

    assign arid    = arid_q;
    assign araddr  = req_q.addr;
    assign arlen   = req_q.len;
    assign arsize  = req_q.size;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign o_err   = err_q;
    assign o_busy  = busy_q;

    // Return beats pass straight through to the owning requester
    assign o_rdata    = rdata;
    assign o_rlast    = rlast;
    assign o_i_rvalid = rready_q && rvalid && (own_d_q == GNT_I);
    assign o_d_rvalid = rready_q && rvalid && (own_d_q == GNT_D);

    // Next-state, latched request, beat count and error tracking
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        arid_d    = arid_q;
        own_d_d   = own_d_q;
        beat_d    = beat_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q;
        busy_d    = busy_q;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d   = ADDR;
                    arvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    own_d_d   = gnt_d;
                    arid_d    = gnt_d ? DCACHE_ID : ICACHE_ID;
                    req_d     = gnt_d ? d_req : i_req;
`ifdef AXI_ARB_ROUND_ROBIN_EN
                    rr_ptr_d  = ~gnt_d;
`endif
                end
            end
            ADDR: begin
                if (arvalid_q && arready) begin
                    state_d   = DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = req_q.len;
                end
            end
            DATA: begin
                if (rvalid) begin
                    if (rlast && (beat_q != 4'd0)) begin
                        err_d = 1'b1;
                    end
                    if (!rlast && (beat_q == 4'd0)) begin
                        err_d = 1'b1;
                    end
                    if (rid != arid_q) begin
                        err_d = 1'b1;
                    end
                    if (rresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    // Saturate: an overrun is flagged, never wrapped
                    if (beat_q != 4'd0) begin
                        beat_d = beat_q - 4'd1;
                    end
                    if (rlast) begin
                        state_d  = IDLE;
                        rready_d = 1'b0;
                        busy_d   = 1'b0;
                        beat_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            req_q     <= '0;
            arid_q    <= 4'd0;
            own_d_q   <= GNT_I;
            beat_q    <= 4'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            rr_ptr_q  <= GNT_D;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            arid_q    <= arid_d;
            own_d_q   <= own_d_d;
            beat_q    <= beat_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

endmodule
